// File: rtl/sigmoid_segment_select.sv
// Sigmoid segment selector: decodes the bf16 exponent of x into one of four
// polynomial segments and emits |x| with that segment's coefficients over a 2-stage handshake pipeline.
module sigmoid_segment_select #(
    parameter int                      DATA_W     = 16,
    parameter int                      COEF_W     = 16,
    parameter logic [16*COEF_W-1:0]    COEF_TABLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic [COEF_W-1:0] a0,
    output logic [COEF_W-1:0] a1,
    output logic [COEF_W-1:0] a2,
    output logic [COEF_W-1:0] offset,
    output logic [1:0]        seg_out,
    output logic              neg_out,
    output logic              sat_out,
    output logic              nan_out
);

    localparam int MANT_W = 7;
    localparam int EXP_W  = 8;
    localparam int ENT_W  = 4 * COEF_W;

    // {seg[1:0], sat, nan} from the exponent/mantissa fields of a bf16 value
    function automatic logic [3:0] decode_seg(input logic [DATA_W-1:0] x);
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        logic [1:0]        seg;
        logic              sat;
        logic              nan;
        e   = x[DATA_W-2 -: EXP_W];
        m   = x[MANT_W-1:0];
        seg = 2'd0;
        sat = 1'b0;
        nan = 1'b0;
        if (e == '1) begin
            seg = 2'd3;
            nan = (m != '0);
            sat = (m == '0);
        end else if (e >= 8'd130) begin
            seg = 2'd3;
            sat = 1'b1;
        end else begin
            case (e)
                8'd127:  seg = 2'd1;
                8'd128:  seg = 2'd2;
                8'd129:  seg = 2'd3;
                default: seg = 2'd0;
            endcase
        end
        return {seg, sat, nan};
    endfunction

    function automatic logic [ENT_W-1:0] coef_entry(input logic [1:0] seg);
        return COEF_TABLE[int'(seg)*ENT_W +: ENT_W];
    endfunction

    logic              vld_p1;
    logic [DATA_W-1:0] x_p1;
    logic [1:0]        seg_p1;
    logic              sat_p1;
    logic              nan_p1;

    logic              vld_p2;
    logic [DATA_W-1:0] mag_p2;
    logic [ENT_W-1:0]  coef_p2;
    logic [1:0]        seg_p2;
    logic              neg_p2;
    logic              sat_p2;
    logic              nan_p2;

    logic              s1_en;
    logic              s2_en;

    // A stage may load when it is empty or when its content moves on this cycle
    assign s2_en    = !vld_p2 || ready_out;
    assign s1_en    = !vld_p1 || s2_en;
    assign ready_in = s1_en;

    // ---- stage 1: capture x with its decoded segment and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            x_p1   <= '0;
            seg_p1 <= '0;
            sat_p1 <= 1'b0;
            nan_p1 <= 1'b0;
        end else begin
            if (s1_en) begin
                vld_p1 <= valid_in;
            end
            if (s1_en && valid_in) begin
                x_p1                     <= data_in;
                {seg_p1, sat_p1, nan_p1} <= decode_seg(data_in);
            end
        end
    end

    // ---- stage 2: output bundle; data only loads with a valid sample so it holds when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2  <= 1'b0;
            mag_p2  <= '0;
            coef_p2 <= '0;
            seg_p2  <= '0;
            neg_p2  <= 1'b0;
            sat_p2  <= 1'b0;
            nan_p2  <= 1'b0;
        end else begin
            if (s2_en) begin
                vld_p2 <= vld_p1;
            end
            if (s2_en && vld_p1) begin
                mag_p2  <= {1'b0, x_p1[DATA_W-2:0]};
                coef_p2 <= coef_entry(seg_p1);
                seg_p2  <= seg_p1;
                neg_p2  <= x_p1[DATA_W-1];
                sat_p2  <= sat_p1;
                nan_p2  <= nan_p1;
            end
        end
    end

    assign valid_out = vld_p2;
    assign data_out  = mag_p2;
    assign offset    = coef_p2[4*COEF_W-1 -: COEF_W];
    assign a2        = coef_p2[3*COEF_W-1 -: COEF_W];
    assign a1        = coef_p2[2*COEF_W-1 -: COEF_W];
    assign a0        = coef_p2[COEF_W-1:0];
    assign seg_out   = seg_p2;
    assign neg_out   = neg_p2;
    assign sat_out   = sat_p2;
    assign nan_out   = nan_p2;

endmodule

// File: doc/sigmoid_segment_select.md
SIGMOID_SEGMENT_SELECT -- requirements
Module: sigmoid_segment_select

Interface
REQ-001 Parameter COEF_TABLE, 256 bits, default all-zero: entry i (i=0..3) = bits [64i+63:64i] = {offset[63:48], a2[47:32], a1[31:16], a0[15:0]}, all bf16.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 valid_in  in  1  upstream sample valid.
REQ-005 ready_in  out  1  block can accept a sample this cycle.
REQ-006 data_in  in  16  bf16 sample x.
REQ-007 valid_out  out  1  output bundle valid.
REQ-008 ready_out  in  1  downstream (polynomial_2nd_degree feed) accepts the bundle.
REQ-009 data_out  out  16  |x|, which is data_in with bit 15 cleared.
REQ-010 a0, a1, a2, offset  out  16 each  coefficients of the selected segment.
REQ-011 seg_out  out  2  selected segment index.
REQ-012 neg_out  out  1  sign bit of x, used by the downstream 1-y symmetry fix-up.
REQ-013 sat_out  out  1  |x| >= 8.0; downstream substitutes 1.0.
REQ-014 nan_out  out  1  x is NaN.

Function
REQ-015 Segment decode on e = data_in[14:7]: e<127 -> seg 0; e==127 -> seg 1; e==128 -> seg 2; e==129 -> seg 3; e>=130 -> seg 3 with sat=1.
REQ-016 Subnormals (e==0) and +/-0 SHALL map to seg 0.
REQ-017 NaN (e==255, mantissa!=0) SHALL set nan=1 and sat=0 with seg 3; +/-Inf SHALL set sat=1 and nan=0.
REQ-018 Coefficient outputs SHALL equal COEF_TABLE entry seg_out and SHALL be registered; no combinational path from data_in to any output.
REQ-019 The block SHALL be a two-stage pipeline. S1 registers x with its decoded seg, sat and nan. S2 registers the full output bundle.
REQ-020 The S2 enable s2_en SHALL be (!s2_valid | ready_out). The S1 enable s1_en SHALL be (!s1_valid | s2_en). ready_in SHALL equal s1_en.
REQ-021 A sample is accepted when valid_in & ready_in. A bundle is consumed when valid_out & ready_out.
REQ-022 Latency SHALL be exactly 2 cycles from acceptance to valid_out when ready_out is held high. Throughput SHALL be 1 sample per cycle.
REQ-023 Under backpressure, at most 2 samples SHALL be held. Order SHALL be preserved with no loss or duplication.
REQ-024 ready_in SHALL be low only when both stages are full and ready_out is low.
REQ-025 While valid_out=1 and ready_out=0, every output SHALL stay stable.
REQ-026 If an accept and a consume occur in the same cycle with both stages full, the pipeline SHALL advance by one stage without a bubble.
REQ-027 Output data fields are don't-care when valid_out=0, but SHALL hold their last value; they SHALL NOT toggle.

Reset
REQ-028 While rst=0, asynchronously: s1_valid=0, s2_valid=0, valid_out=0, and all data, coefficient and flag registers = 0. ready_in SHALL therefore read 1.
REQ-029 Reset mid-operation SHALL discard all in-flight samples. No sample accepted before reset SHALL appear after it.
REQ-030 The first accept SHALL be possible in the first rising edge after rst deasserts.

Verification
REQ-031 x=0x3F00 (0.5), ready_out=1 -> 2 cycles later: valid_out=1, data_out=0x3F00, seg_out=0, neg_out=0, sat_out=0, nan_out=0, coefficients = entry 0.
REQ-032 x=0xC040 (-3.0) -> data_out=0x4040, seg_out=2, neg_out=1, coefficients = entry 2.
REQ-033 x=0x4100 (8.0) -> sat_out=1, seg_out=3. x=0xFF80 (-Inf) -> sat_out=1, neg_out=1. x=0x7FC0 (NaN) -> nan_out=1, sat_out=0.
REQ-034 Backpressure: ready_out=0 while pushing 0x3F80, 0x4000, 0x4080 back-to-back.
- First two are accepted; ready_in=0 on the third.
- After ready_out rises, the bundles emerge in order (seg 1, 2, 3) and the third is then accepted.
REQ-035 Streaming: 100 random samples with random ready_out.
- Scoreboard confirms order, field values and stability under stall.
- Accept-and-consume in the same cycle produces no bubble.
REQ-036 Reset mid-operation: assert rst with 2 samples in flight.
- valid_out drops immediately.
- After release, no stale bundle appears and a new sample emerges at latency 2.
